// File: rtl/ram_ctrl_pkg.sv
// Shared helpers and limits for RAM-port controllers and arbiters.
package ram_ctrl_pkg;

  localparam int unsigned MAX_NUM_REQ   = 8;
  localparam int unsigned MAX_BURST_MAX = 16;
  localparam int unsigned MAX_IDX_W     = $clog2(MAX_NUM_REQ);

  // Address width that stays at least 1 bit for tiny memories.
  function automatic int unsigned clog2_safe(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_port_rr_arbiter_if.sv
// Requester bundle plus the shared RAM port driven by the arbiter.
interface ram_port_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AW      = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;
  logic                     ram_en;
  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [WIDTH-1:0]         ram_din;
  logic [WIDTH-1:0]         ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [N-1:0]          gnt,
  output logic [$clog2(N)-1:0]  idx,
  output logic                  any
);
  localparam int unsigned IW = $clog2(N);

  int unsigned j;

  always_comb begin
    gnt = '0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (req[j] && (gnt == '0)) gnt[j] = 1'b1;
    end
  end

  assign any = |req;
  assign idx = IW'(onehot_to_idx(MAX_NUM_REQ'(gnt)));

endmodule

// File: rtl/ram_port_rr_arbiter.sv
// Round-robin arbiter with bounded burst tenure sharing one synchronous RAM port.
module ram_port_rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BURST_MAX = 4
) (
  input logic                   clk,
  input logic                   rst,
  ram_port_rr_arbiter_if.slave  bus
);
  localparam int unsigned AW = clog2_safe(DEPTH);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      burst_cnt;
  logic [NUM_REQ-1:0] rd_tag;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               cont;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      g_idx;
  logic               grant_any;
  logic               gnt_we;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign cont = (burst_cnt != '0) && bus.req_valid[owner] && (burst_cnt < CW'(BURST_MAX));

  always_comb begin
    gnt   = '0;
    g_idx = '0;
    if (!rst) begin
      if (cont) begin
        gnt[owner] = 1'b1;
        g_idx      = owner;
      end else if (pick_any) begin
        gnt   = pick_gnt;
        g_idx = pick_idx;
      end
    end
  end

  assign grant_any = |gnt;

  always_comb begin
    gnt_we       = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_we       = bus.req_we[i];
        bus.ram_addr = bus.req_addr[i*AW +: AW];
        bus.ram_din  = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.ram_en    = grant_any;
  assign bus.ram_we    = grant_any & gnt_we;
  // Gating by rst drops a response whose read was granted just before reset.
  assign bus.rsp_valid = rst ? '0 : rd_tag;
  assign bus.rsp_rdata = bus.ram_dout;

  // A fresh pick always restarts tenure at 1, even when it re-selects the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rd_tag    <= '0;
    end else begin
      rd_tag <= (grant_any && !gnt_we) ? gnt : '0;
      if (!grant_any) begin
        burst_cnt <= '0;
      end else if (cont) begin
        burst_cnt <= burst_cnt + CW'(1);
      end else begin
        owner     <= g_idx;
        burst_cnt <= CW'(1);
        ptr       <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_port_rr_arbiter.sv
// Directed bench: two arbiter instances (BURST_MAX 4 and 1) against a registered RAM model.
module tb_ram_port_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ram_port_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .AW(8)) bus0 ();
  ram_port_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .AW(8)) bus1 ();

  ram_port_rr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(256), .BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ram_port_rr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(256), .BURST_MAX(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus0.ram_en) begin
      if (bus0.ram_we) mem[bus0.ram_addr] <= bus0.ram_din;
      else             bus0.ram_dout      <= mem[bus0.ram_addr];
    end
  end
  assign bus1.ram_dout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic [3:0] v, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus0.req_valid = v;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
  endtask

  task automatic to_check;
    @(negedge clk);
  endtask

  task automatic to_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus0.req_ready), 32'h0);
    chk({tag, "_en"},    32'(bus0.ram_en),    32'h0);
    chk({tag, "_rsp"},   32'(bus0.rsp_valid), 32'h0);
  endtask

  logic [3:0] cap_exp  [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1};
  logic [3:0] wrap_exp [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

  initial begin
    rst = 1'b1;
    drive0(4'h0, 4'h0, 32'h0, 32'h0);
    bus1.req_valid = '0;
    bus1.req_we    = '0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;

    for (int i = 0; i < 3; i++) begin
      to_check; chk_idle($sformatf("rst%0d", i)); to_drive;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_check; chk_idle($sformatf("idle%0d", i)); to_drive;
    end

    // req 1 writes A5 to 0x10, then reads it back
    drive0(4'b0010, 4'b0010, 32'h0000_1000, 32'h0000_A500);
    to_check;
    chk("wr_ready", 32'(bus0.req_ready), 32'h2);
    chk("wr_en",    32'(bus0.ram_en),    32'h1);
    chk("wr_we",    32'(bus0.ram_we),    32'h1);
    chk("wr_addr",  32'(bus0.ram_addr),  32'h10);
    chk("wr_din",   32'(bus0.ram_din),   32'hA5);
    to_drive;
    drive0(4'b0010, 4'b0000, 32'h0000_1000, 32'h0);
    to_check;
    chk("rd_ready", 32'(bus0.req_ready), 32'h2);
    chk("rd_we",    32'(bus0.ram_we),    32'h0);
    chk("rd_rsp0",  32'(bus0.rsp_valid), 32'h0);
    to_drive;
    drive0(4'h0, 4'h0, 32'h0, 32'h0);
    to_check;
    chk("rd_rsp1",  32'(bus0.rsp_valid), 32'h2);
    chk("rd_data",  32'(bus0.rsp_rdata), 32'hA5);
    chk("rd_idle",  32'(bus0.req_ready), 32'h0);
    to_drive;

    // preload 0x11 @5 by req 0 and 0x22 @6 by req 1, then pipelined reads
    drive0(4'b0001, 4'b0001, 32'h0000_0005, 32'h0000_0011);
    to_check; chk("pl0_ready", 32'(bus0.req_ready), 32'h1); to_drive;
    drive0(4'b0010, 4'b0010, 32'h0000_0600, 32'h0000_2200);
    to_check; chk("pl1_ready", 32'(bus0.req_ready), 32'h2); to_drive;
    drive0(4'b0001, 4'b0000, 32'h0000_0005, 32'h0);
    to_check;
    chk("pr0_ready", 32'(bus0.req_ready), 32'h1);
    chk("pr0_rsp",   32'(bus0.rsp_valid), 32'h0);
    to_drive;
    drive0(4'b0010, 4'b0000, 32'h0000_0600, 32'h0);
    to_check;
    chk("pr1_ready", 32'(bus0.req_ready), 32'h2);
    chk("pr1_rsp",   32'(bus0.rsp_valid), 32'h1);
    chk("pr1_data",  32'(bus0.rsp_rdata), 32'h11);
    to_drive;
    drive0(4'h0, 4'h0, 32'h0, 32'h0);
    to_check;
    chk("pr2_rsp",   32'(bus0.rsp_valid), 32'h2);
    chk("pr2_data",  32'(bus0.rsp_rdata), 32'h22);
    to_drive;

    rst = 1'b1;
    to_check; chk_idle("rst_b"); to_drive;
    rst = 1'b0;

    // burst cap: req 0 and req 2 read continuously
    drive0(4'b0101, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      to_check; chk($sformatf("cap%0d", i), 32'(bus0.req_ready), 32'(cap_exp[i])); to_drive;
    end
    drive0(4'h0, 4'h0, 32'h0, 32'h0);
    to_check;
    chk("cap_end_rsp",   32'(bus0.rsp_valid), 32'h1);
    chk("cap_end_ready", 32'(bus0.req_ready), 32'h0);
    to_drive;

    // burst break: req 3 for two cycles, then only req 1
    drive0(4'b1000, 4'b0000, 32'h0, 32'h0);
    to_check; chk("brk0", 32'(bus0.req_ready), 32'h8); to_drive;
    to_check;
    chk("brk1",     32'(bus0.req_ready), 32'h8);
    chk("brk1_rsp", 32'(bus0.rsp_valid), 32'h8);
    to_drive;
    drive0(4'b0010, 4'b0000, 32'h0000_1000, 32'h0);
    to_check; chk("brk2", 32'(bus0.req_ready), 32'h2); to_drive;

    // reset lands while req 1's read response is in flight
    rst = 1'b1;
    to_check; chk_idle("rst_fl"); to_drive;
    rst = 1'b0;
    drive0(4'b1111, 4'b0000, 32'h0, 32'h0);
    to_check;
    chk("post_rst_ready", 32'(bus0.req_ready), 32'h1);
    chk("post_rst_rsp",   32'(bus0.rsp_valid), 32'h0);
    to_drive;
    drive0(4'h0, 4'h0, 32'h0, 32'h0);

    // BURST_MAX = 1 instance: strict rotation with wrap
    bus1.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      to_check; chk($sformatf("wrap%0d", i), 32'(bus1.req_ready), 32'(wrap_exp[i])); to_drive;
    end
    bus1.req_valid = '0;
    to_check; chk("wrap_idle", 32'(bus1.ram_en), 32'h0); to_drive;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
